// File: rtl/rs_pkg.sv
// Shared Reed-Solomon package.
// Holds the default symbol width and root-array depth, the GF(2^m) multiplicative
// group order (2^m - 1), the root-table FSM state type and exp_wrap(), which folds
// an exponent back into 0 .. 2^m-2. The syndrome and Chien blocks reuse these
// definitions.
package rs_pkg;

   localparam int SYM_W      = 8;
   localparam int MAX_PARITY = 32;
   localparam int GF_MOD     = (1 << SYM_W) - 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_READY = 2'd3
   } rs_state_e;

   // alpha^GF_MOD == alpha^0, so exponents live modulo the group order
   function automatic int unsigned exp_wrap(input int unsigned e, input int unsigned modulus);
      return e % modulus;
   endfunction

endpackage

// File: rtl/rs_root_table_if.sv
// Bus bundle for rs_root_table.
// Groups the load control, GF antilog-table handshake and the two root read
// ports. The slave modport is the root table's view; the master modport is the
// view of the surrounding logic (controller, GF table, syndrome and Chien stages).
interface rs_root_table_if #(
   parameter int SYM_W = 8,
   parameter int IDX_W = 8
);
   // load control
   logic             load_start;
   logic [IDX_W-1:0] no_of_parity;
   logic             load_done;
   logic             table_valid;
   logic             cfg_error;
   // antilog table handshake
   logic             gf_read;
   logic [SYM_W-1:0] gf_addr;
   logic             gf_table_ready;
   logic [SYM_W-1:0] gf_data;
   // syndrome read port
   logic             synd_req;
   logic [IDX_W-1:0] synd_addr;
   logic [SYM_W-1:0] synd_root;
   logic             synd_valid;
   logic             synd_oob;
   // Chien read port
   logic             chien_req;
   logic [IDX_W-1:0] chien_addr;
   logic [SYM_W-1:0] chien_root;
   logic             chien_valid;
   logic             chien_oob;

   modport slave (
      input  load_start, no_of_parity, gf_table_ready, gf_data,
             synd_req, synd_addr, chien_req, chien_addr,
      output load_done, table_valid, cfg_error, gf_read, gf_addr,
             synd_root, synd_valid, synd_oob,
             chien_root, chien_valid, chien_oob
   );

   modport master (
      output load_start, no_of_parity, gf_table_ready, gf_data,
             synd_req, synd_addr, chien_req, chien_addr,
      input  load_done, table_valid, cfg_error, gf_read, gf_addr,
             synd_root, synd_valid, synd_oob,
             chien_root, chien_valid, chien_oob
   );

endinterface

// File: rtl/rs_root_rd_port.sv
// Registered root read port with range check.
// A request is honoured only while the table is valid. In-range indices
// (addr < limit) return root_sel one cycle later with valid; out-of-range indices
// raise oob for one cycle and leave root unchanged. Requests while the table is
// invalid produce nothing.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   table_valid    root array holds a complete set of roots
//   limit          number of legal indices for this port
//   req, addr      read request and root index
//   root_sel       array word currently addressed by addr
//   root, valid, oob  registered response
module rs_root_rd_port #(
   parameter int SYM_W = 8,
   parameter int IDX_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             table_valid,
   input  logic [IDX_W-1:0] limit,
   input  logic             req,
   input  logic [IDX_W-1:0] addr,
   input  logic [SYM_W-1:0] root_sel,
   output logic [SYM_W-1:0] root,
   output logic             valid,
   output logic             oob
);

   logic [SYM_W-1:0] root_p1;
   logic             vld_p1;
   logic             oob_p1;

   // request -> registered response (one-cycle latency)
   always_ff @(posedge clock) begin
      if (reset) begin
         root_p1 <= '0;
         vld_p1  <= 1'b0;
         oob_p1  <= 1'b0;
      end else begin
         vld_p1 <= 1'b0;
         oob_p1 <= 1'b0;
         if (req && table_valid) begin
            if (addr < limit) begin
               vld_p1  <= 1'b1;
               root_p1 <= root_sel;
            end else begin
               oob_p1  <= 1'b1;
            end
         end
      end
   end

   assign root  = root_p1;
   assign valid = vld_p1;
   assign oob   = oob_p1;

endmodule

// File: rtl/rs_root_table.sv
// Generator-polynomial root store for the Reed-Solomon codec.
// On load_start with a legal parity count n it fetches alpha^(FCR+i), i=0..n-1,
// one at a time from the GF antilog table (gf_read strobe, wait for
// gf_table_ready), stores them locally, then pulses load_done and raises
// table_valid. Two independent registered read ports serve the syndrome stage
// (indices < n) and the Chien/locator stage (indices < n/2).
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   bus            rs_root_table_if.slave: load control, table handshake,
//                  syndrome and Chien read ports
module rs_root_table #(
   parameter int SYM_W      = rs_pkg::SYM_W,
   parameter int MAX_PARITY = rs_pkg::MAX_PARITY,
   parameter int FCR        = 1,
   parameter int IDX_W      = 8
) (
   input logic           clock,
   input logic           reset,
   rs_root_table_if.slave bus
);
   import rs_pkg::*;

   localparam int               SYM_MOD  = (1 << SYM_W) - 1;
   localparam int               AW       = (MAX_PARITY > 1) ? $clog2(MAX_PARITY) : 1;
   localparam logic [SYM_W-1:0] EXP0     = SYM_W'(exp_wrap(FCR, SYM_MOD));
   localparam logic [SYM_W-1:0] EXP_LAST = SYM_W'(SYM_MOD - 1);

   rs_state_e        state;
   logic [IDX_W-1:0] n_q;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_nxt;
   logic [SYM_W-1:0] addr_q;
   logic             read_q;
   logic             done_q;
   logic             valid_q;
   logic             err_q;
   logic             n_bad;
   logic             take_root;
   logic [IDX_W-1:0] chien_limit;
   logic [SYM_W-1:0] synd_sel;
   logic [SYM_W-1:0] chien_sel;

   logic [SYM_W-1:0] roots [MAX_PARITY];

   assign n_bad     = (bus.no_of_parity == '0) || (int'(bus.no_of_parity) > MAX_PARITY);
   assign idx_nxt   = idx_q + IDX_W'(1);
   assign take_root = (state == ST_WAIT) && bus.gf_table_ready;

   // Load sequencer. gf_read is registered, so it is raised on the transition
   // into ISSUE and dropped on the transition into WAIT; gf_addr is only updated
   // when entering ISSUE and therefore stays stable throughout WAIT.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= ST_IDLE;
         n_q     <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         read_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE, ST_READY: begin
               if (bus.load_start) begin
                  valid_q <= 1'b0;
                  if (n_bad) begin
                     err_q <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     err_q  <= 1'b0;
                     n_q    <= bus.no_of_parity;
                     idx_q  <= '0;
                     addr_q <= EXP0;
                     read_q <= 1'b1;
                     state  <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               read_q <= 1'b0;
               state  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.gf_table_ready) begin
                  idx_q <= idx_nxt;
                  if (idx_nxt == n_q) begin
                     done_q  <= 1'b1;
                     valid_q <= 1'b1;
                     state   <= ST_READY;
                  end else begin
                     // exponent 2^m-1 aliases exponent 0, so skip straight to 0
                     addr_q <= (addr_q == EXP_LAST) ? '0 : addr_q + SYM_W'(1);
                     read_q <= 1'b1;
                     state  <= ST_ISSUE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Root storage carries no reset; contents are qualified by table_valid.
   always_ff @(posedge clock) begin
      if (!reset && take_root) begin
         roots[idx_q[AW-1:0]] <= bus.gf_data;
      end
   end

   // Array lookups; indices beyond the array are rejected by the range check
   // in the port whenever the table is valid, so the zero default is never returned.
   assign synd_sel    = (int'(bus.synd_addr) < MAX_PARITY)  ? roots[bus.synd_addr[AW-1:0]]  : '0;
   assign chien_sel   = (int'(bus.chien_addr) < MAX_PARITY) ? roots[bus.chien_addr[AW-1:0]] : '0;
   assign chien_limit = n_q >> 1;

   rs_root_rd_port #(.SYM_W(SYM_W), .IDX_W(IDX_W)) u_synd_port (
      .clock       (clock),
      .reset       (reset),
      .table_valid (valid_q),
      .limit       (n_q),
      .req         (bus.synd_req),
      .addr        (bus.synd_addr),
      .root_sel    (synd_sel),
      .root        (bus.synd_root),
      .valid       (bus.synd_valid),
      .oob         (bus.synd_oob)
   );

   rs_root_rd_port #(.SYM_W(SYM_W), .IDX_W(IDX_W)) u_chien_port (
      .clock       (clock),
      .reset       (reset),
      .table_valid (valid_q),
      .limit       (chien_limit),
      .req         (bus.chien_req),
      .addr        (bus.chien_addr),
      .root_sel    (chien_sel),
      .root        (bus.chien_root),
      .valid       (bus.chien_valid),
      .oob         (bus.chien_oob)
   );

   assign bus.gf_read     = read_q;
   assign bus.gf_addr     = addr_q;
   assign bus.load_done   = done_q;
   assign bus.table_valid = valid_q;
   assign bus.cfg_error   = err_q;

endmodule
